updown_count_unit: RTL and testbench

//   Downstream consumer of the inc/dec pulse FSM. Each accepted inc pulse

---
 rtl/updown_count_unit.sv | 131 +++++++++++++
 tb/tb_updown_count_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_count_unit.sv
// updown_count_unit: bounded up/down counter fed by inc/dec pulses.
// Tracks last movement direction (IDLE/UP/DOWN) and keeps sticky
// overflow/underflow flags at the range limits.
// Optional feature macro: UDC_SATURATE_EN
//   defined   -> inc at MAX / dec at MIN hold the count at the limit
//   undefined -> inc at MAX wraps to MIN, dec at MIN wraps to MAX
module updown_count_unit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MIN   = 0,
  parameter int unsigned MAX   = 9,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf,
  output logic             changed,
  output logic             dir_up,
  output logic             dir_dn
);

  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic             r_changed;
  state_t           r_state;

  logic [WIDTH-1:0] w_loadClip;
  logic [WIDTH-1:0] w_nextCount;
  state_t           w_nextState;
  logic             w_setOvf;
  logic             w_setUnf;

  // Clip the load value into [MIN,MAX]; the <= / >= forms keep the
  // comparisons meaningful even when a limit sits at the edge of the range.
  always_comb begin
    w_loadClip = load_val;
    if (load_val <= MIN_V) begin
      w_loadClip = MIN_V;
    end else if (load_val >= MAX_V) begin
      w_loadClip = MAX_V;
    end
  end

  // Next count, direction and flag-set events, in priority order:
  // load, then simultaneous inc/dec (no-op), then inc, then dec.
  // The range check happens before any +1/-1, so no intermediate wraps.
  always_comb begin
    w_nextCount = r_count;
    w_nextState = r_state;
    w_setOvf    = 1'b0;
    w_setUnf    = 1'b0;
    if (load) begin
      w_nextCount = w_loadClip;
      w_nextState = ST_IDLE;
    end else if (inc && dec) begin
      w_nextCount = r_count;
    end else if (inc) begin
      w_nextState = ST_UP;
      if (r_count >= MAX_V) begin
        w_setOvf = 1'b1;
`ifdef UDC_SATURATE_EN
        w_nextCount = MAX_V;
`else
        w_nextCount = MIN_V;
`endif
      end else begin
        w_nextCount = r_count + ONE_V;
      end
    end else if (dec) begin
      w_nextState = ST_DOWN;
      if (r_count <= MIN_V) begin
        w_setUnf = 1'b1;
`ifdef UDC_SATURATE_EN
        w_nextCount = MIN_V;
`else
        w_nextCount = MAX_V;
`endif
      end else begin
        w_nextCount = r_count - ONE_V;
      end
    end
  end

  // Register count, direction FSM, sticky flags (set beats clear) and
  // the one-cycle changed pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= INIT_V;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_changed <= 1'b0;
      r_state   <= ST_IDLE;
    end else begin
      r_count   <= w_nextCount;
      r_state   <= w_nextState;
      r_ovf     <= w_setOvf | (r_ovf & ~clr_flags);
      r_unf     <= w_setUnf | (r_unf & ~clr_flags);
      r_changed <= (w_nextCount != r_count);
    end
  end

  assign count   = r_count;
  assign at_max  = (r_count == MAX_V);
  assign at_min  = (r_count == MIN_V);
  assign ovf     = r_ovf;
  assign unf     = r_unf;
  assign changed = r_changed;
  assign dir_up  = (r_state == ST_UP);
  assign dir_dn  = (r_state == ST_DOWN);

endmodule

// File: tb/tb_updown_count_unit.sv
// Testbench for updown_count_unit (WIDTH=4, MIN=0, MAX=9, INIT=0).
// Expected outputs come from a behavioural model and are queued per cycle;
// a monitor process pops and compares one entry after every clock edge.
module tb_updown_count_unit;

  localparam int WIDTH = 4;
  localparam int MIN   = 0;
  localparam int MAX   = 9;
  localparam int INIT  = 0;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             atMax;
    logic             atMin;
    logic             ovf;
    logic             unf;
    logic             changed;
    logic             dirUp;
    logic             dirDn;
  } obs_t;

  logic             clk;
  logic             reset;
  logic             inc;
  logic             dec;
  logic             load;
  logic [WIDTH-1:0] loadVal;
  logic             clrFlags;
  logic [WIDTH-1:0] count;
  logic             atMax;
  logic             atMin;
  logic             ovf;
  logic             unf;
  logic             changed;
  logic             dirUp;
  logic             dirDn;

  int checks = 0;
  int errors = 0;

  obs_t expQ[$];

  // Behavioural model state: count as a plain integer, direction as
  // 0=idle, 1=up, 2=down.
  int mCount;
  bit mOvf;
  bit mUnf;
  bit mChanged;
  int mDir;

  updown_count_unit #(
    .WIDTH(WIDTH), .MIN(MIN), .MAX(MAX), .INIT(INIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inc(inc),
    .dec(dec),
    .load(load),
    .load_val(loadVal),
    .clr_flags(clrFlags),
    .count(count),
    .at_max(atMax),
    .at_min(atMin),
    .ovf(ovf),
    .unf(unf),
    .changed(changed),
    .dir_up(dirUp),
    .dir_dn(dirDn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t modelObs();
    obs_t o;
    o.count   = WIDTH'(mCount);
    o.atMax   = (mCount == MAX);
    o.atMin   = (mCount == MIN);
    o.ovf     = mOvf;
    o.unf     = mUnf;
    o.changed = mChanged;
    o.dirUp   = (mDir == 1);
    o.dirDn   = (mDir == 2);
    return o;
  endfunction

  function automatic obs_t dutObs();
    obs_t o;
    o.count   = count;
    o.atMax   = atMax;
    o.atMin   = atMin;
    o.ovf     = ovf;
    o.unf     = unf;
    o.changed = changed;
    o.dirUp   = dirUp;
    o.dirDn   = dirDn;
    return o;
  endfunction

  task automatic modelReset();
    mCount   = INIT;
    mOvf     = 1'b0;
    mUnf     = 1'b0;
    mChanged = 1'b0;
    mDir     = 0;
  endtask

  task automatic checkOutput(input string name, input obs_t exp);
    obs_t act;
    act = dutObs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got count=%0d atMax=%0b atMin=%0b ovf=%0b unf=%0b chg=%0b up=%0b dn=%0b, want count=%0d atMax=%0b atMin=%0b ovf=%0b unf=%0b chg=%0b up=%0b dn=%0b",
               name, act.count, act.atMax, act.atMin, act.ovf, act.unf,
               act.changed, act.dirUp, act.dirDn, exp.count, exp.atMax,
               exp.atMin, exp.ovf, exp.unf, exp.changed, exp.dirUp, exp.dirDn);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model by
  // the rules of the block and queue the response expected after the
  // following rising edge.
  task automatic applyStimulus(input bit r, input bit i, input bit d,
                               input bit l, input int lv, input bit c);
    int oldCount;
    bit setO;
    bit setU;
    @(negedge clk);
    reset    = r;
    inc      = i;
    dec      = d;
    load     = l;
    loadVal  = WIDTH'(lv);
    clrFlags = c;
    if (r) begin
      modelReset();
    end else begin
      oldCount = mCount;
      setO = 1'b0;
      setU = 1'b0;
      if (l) begin
        mCount = (lv < MIN) ? MIN : ((lv > MAX) ? MAX : lv);
        mDir   = 0;
      end else if (i && d) begin
        mCount = oldCount;
      end else if (i) begin
        mDir = 1;
        if (mCount == MAX) begin
          setO = 1'b1;
`ifdef UDC_SATURATE_EN
          mCount = MAX;
`else
          mCount = MIN;
`endif
        end else begin
          mCount = mCount + 1;
        end
      end else if (d) begin
        mDir = 2;
        if (mCount == MIN) begin
          setU = 1'b1;
`ifdef UDC_SATURATE_EN
          mCount = MIN;
`else
          mCount = MAX;
`endif
        end else begin
          mCount = mCount - 1;
        end
      end
      if (c) begin
        mOvf = 1'b0;
        mUnf = 1'b0;
      end
      mOvf     = mOvf | setO;
      mUnf     = mUnf | setU;
      mChanged = (mCount != oldCount);
    end
    expQ.push_back(modelObs());
  endtask

  // Monitor: one queued expectation is consumed after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        checkOutput("scoreboard", expQ.pop_front());
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Main sequence: directed scenarios followed by a randomized run.
  initial begin
    obs_t resetExp;
    resetExp = '{count: WIDTH'(INIT), atMax: (INIT == MAX), atMin: (INIT == MIN),
                 ovf: 1'b0, unf: 1'b0, changed: 1'b0, dirUp: 1'b0, dirDn: 1'b0};
    reset = 1'b1; inc = 1'b0; dec = 1'b0; load = 1'b0;
    loadVal = '0; clrFlags = 1'b0;
    modelReset();
    #2;
    checkOutput("resetInitial", resetExp);

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Three single-cycle inc pulses separated by idle cycles
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end

    // Load above range clips to MAX, then inc at MAX
    applyStimulus(0, 0, 0, 1, 15, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Dec at MIN, then clear flags with no new event
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // inc and dec together hold; load beats inc
    applyStimulus(0, 0, 0, 1, 5, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 2, 0);

    // Set wins over clear: ovf raised, count reloaded to MAX, clr with inc
    applyStimulus(0, 0, 0, 1, 9, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 9, 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Async reset mid-cycle during an inc burst
    applyStimulus(0, 0, 0, 1, 3, 1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncReset", resetExp);
    modelReset();
    applyStimulus(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      int sel;
      bit ri, rd, rl, rc;
      sel = $urandom_range(0, 99);
      rl  = (sel < 8);
      rc  = ($urandom_range(0, 9) == 0);
      ri  = $urandom_range(0, 1);
      rd  = $urandom_range(0, 2) == 0;
      applyStimulus(0, ri, rd, rl, $urandom_range(0, 15), rc);
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queueDrain: got %0d pending, want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
